// File: rtl/sodor_rtype_seq_ctrl_pkg.sv
// Shared types and constants for the sodor3 random ALU stimulus controller.
// IMM_TYPE_EN (optional) enables mixed R-type / OP-IMM generation.
package sodor_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_COMPARE,
    S_DONE
  } state_e;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;

  localparam logic [31:0] LFSR_POLY      = 32'h8020_0003;
  localparam logic [11:0] SHAMT_MASK_SLL = 12'h01F;
  localparam logic [11:0] SHAMT_MASK_SRX = 12'h41F;

endpackage

// File: rtl/sodor_rtype_seq_ctrl_if.sv
// Stimulus/compare bus between the sequencer and the core harness.
// master = sequencer, slave = harness holding both register files.
interface sodor_rtype_seq_ctrl_if;

  logic        start;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic [4:0]  rf_idx;
  logic [31:0] rf_dut_data;
  logic [31:0] rf_ref_data;
  logic        busy;
  logic        done;
  logic        mismatch;
  logic [4:0]  mismatch_idx;
  logic [15:0] issued_cnt;

  modport master (
    input  start,
    input  rf_dut_data,
    input  rf_ref_data,
    output instr_out,
    output instr_valid,
    output rf_idx,
    output busy,
    output done,
    output mismatch,
    output mismatch_idx,
    output issued_cnt
  );

  modport slave (
    output start,
    output rf_dut_data,
    output rf_ref_data,
    input  instr_out,
    input  instr_valid,
    input  rf_idx,
    input  busy,
    input  done,
    input  mismatch,
    input  mismatch_idx,
    input  issued_cnt
  );

endinterface

// File: rtl/sodor_rtype_seq_ctrl_lfsr.sv
// 32-bit right-shifting Galois LFSR; steps only when advance is high.
module seq_lfsr32
  import sodor_seq_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0001_17E4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  output logic [31:0] value
);

  logic [31:0] lfsr_q;
  logic [31:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (advance)
      lfsr_d = {1'b0, lfsr_q[31:1]}
             ^ (lfsr_q[0] ? LFSR_POLY : 32'h0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign value = lfsr_q;

endmodule

// File: rtl/sodor_rtype_seq_ctrl.sv
// Random ALU instruction issuer + register-file cross-checker for sodor3.
// Define IMM_TYPE_EN to mix OP-IMM instructions into the stream.
module sodor_rtype_seq_ctrl
  import sodor_seq_pkg::*;
#(
  parameter int unsigned NUM_INSTR    = 100,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter logic [31:0] SEED         = 32'h0001_17E4
) (
  input  logic                   clk,
  input  logic                   reset,
  sodor_rtype_seq_ctrl_if.master bus
);

  localparam logic [15:0] NUM = 16'(NUM_INSTR);
  localparam logic [15:0] DRN = 16'(DRAIN_CYCLES);

  // Zero-length phases are skipped entirely.
  localparam state_e AFTER_ISSUE =
    (DRN != 16'd0) ? S_DRAIN : S_COMPARE;
  localparam state_e AFTER_START =
    (NUM != 16'd0) ? S_ISSUE : AFTER_ISSUE;

  state_e      state_q, state_d;
  logic [31:0] instr_q;
  logic        valid_q;
  logic [4:0]  rf_idx_q;
  logic        busy_q;
  logic        done_q;
  logic        mism_q;
  logic [4:0]  midx_q;
  logic [15:0] issued_q;
  logic [15:0] cnt_q;

  logic        start_ok;
  logic        advance;
  logic [31:0] lfsr;
  logic        unused_lfsr;

  function automatic logic [31:0] encode(
    input logic [31:0] l
  );
    logic [2:0]  f3;
    logic [6:0]  f7;
`ifdef IMM_TYPE_EN
    logic [11:0] imm;
`endif
    f3 = l[14:12];
    f7 = (f3 == 3'd0 || f3 == 3'd5)
       ? {1'b0, l[30], 5'b0} : 7'b0;
    encode = {f7, l[24:20], l[19:15],
              f3, l[11:7], OPC_OP};
`ifdef IMM_TYPE_EN
    imm = l[29:18];
    if (f3 == 3'd1)
      imm = imm & SHAMT_MASK_SLL;
    else if (f3 == 3'd5)
      imm = imm & SHAMT_MASK_SRX;
    if (!l[31])
      encode = {imm, l[19:15], f3,
                l[11:7], OPC_OP_IMM};
`endif
  endfunction

  seq_lfsr32 #(.SEED(SEED)) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (advance),
    .value   (lfsr)
  );

  assign unused_lfsr = ^lfsr;

  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          start_ok = 1'b1;
          state_d  = AFTER_START;
        end
      end
      S_ISSUE:
        if (issued_q == NUM) state_d = AFTER_ISSUE;
      S_DRAIN:
        if (cnt_q == DRN) state_d = S_COMPARE;
      S_COMPARE:
        if (rf_idx_q == 5'd31) state_d = S_DONE;
      default:
        state_d = S_IDLE;
    endcase
  end

  // A new instruction is latched whenever the next state is ISSUE.
  assign advance = (state_d == S_ISSUE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      instr_q  <= NOP_INSTR;
      valid_q  <= 1'b0;
      rf_idx_q <= 5'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mism_q   <= 1'b0;
      midx_q   <= 5'd0;
      issued_q <= 16'd0;
      cnt_q    <= 16'd0;
    end else begin
      state_q <= state_d;
      instr_q <= advance ? encode(lfsr) : NOP_INSTR;
      valid_q <= (state_d == S_ISSUE)
              || (state_d == S_DRAIN);
      busy_q  <= (state_d == S_ISSUE)
              || (state_d == S_DRAIN)
              || (state_d == S_COMPARE);
      done_q  <= (state_d == S_DONE);

      if (state_d == S_DRAIN)
        cnt_q <= (state_q == S_DRAIN)
               ? cnt_q + 16'd1 : 16'd1;
      else
        cnt_q <= 16'd0;

      // x0 is never compared: idx starts at 1.
      if (state_d == S_COMPARE)
        rf_idx_q <= (state_q == S_COMPARE)
                  ? rf_idx_q + 5'd1 : 5'd1;
      else
        rf_idx_q <= 5'd0;

      if (start_ok) begin
        mism_q   <= 1'b0;
        midx_q   <= 5'd0;
        issued_q <= advance ? 16'd1 : 16'd0;
      end else begin
        if (advance && issued_q != 16'hFFFF)
          issued_q <= issued_q + 16'd1;
        if (state_q == S_COMPARE && !mism_q
            && bus.rf_dut_data != bus.rf_ref_data) begin
          mism_q <= 1'b1;
          midx_q <= rf_idx_q;
        end
      end
    end
  end

  assign bus.instr_out    = instr_q;
  assign bus.instr_valid  = valid_q;
  assign bus.rf_idx       = rf_idx_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.mismatch     = mism_q;
  assign bus.mismatch_idx = midx_q;
  assign bus.issued_cnt   = issued_q;

endmodule

// File: tb/tb_sodor_rtype_seq_ctrl.sv
// Randomized self-checking bench for sodor_rtype_seq_ctrl against a
// sequence-level reference model (LFSR stream + run timeline).
module tb_sodor_rtype_seq_ctrl;

  localparam int          NI   = 4;
  localparam int          DC   = 3;
  localparam logic [31:0] SEED = 32'h0001_17E4;
  localparam logic [31:0] POLY = 32'h8020_0003;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  sodor_rtype_seq_ctrl_if bus();

  sodor_rtype_seq_ctrl #(
    .NUM_INSTR    (NI),
    .DRAIN_CYCLES (DC),
    .SEED         (SEED)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] dut_rf [32];
  logic [31:0] ref_rf [32];

  assign bus.rf_dut_data = dut_rf[bus.rf_idx];
  assign bus.rf_ref_data = ref_rf[bus.rf_idx];

  int checks = 0;
  int errors = 0;

  logic [31:0] model_l;
  logic [31:0] run_seq [$];
  logic [31:0] first_seq [$];

  function automatic logic [31:0] m_next(input logic [31:0] l);
    return (l >> 1) ^ (((l & 32'd1) != 0) ? POLY : 32'd0);
  endfunction

  function automatic logic [31:0] m_enc(input logic [31:0] l);
    logic [31:0] f3, rd, rs1, rs2, f7, imm, r;
    f3  = (l >> 12) & 32'd7;
    rd  = (l >> 7) & 32'd31;
    rs1 = (l >> 15) & 32'd31;
    rs2 = (l >> 20) & 32'd31;
    f7  = (f3 == 0 || f3 == 5) ? ((l >> 30) & 32'd1) * 32 : 32'd0;
    r   = (f7 << 25) | (rs2 << 20) | (rs1 << 15)
        | (f3 << 12) | (rd << 7) | 32'd51;
`ifdef IMM_TYPE_EN
    imm = (l >> 18) & 32'hFFF;
    if (f3 == 1) imm = imm & 32'h01F;
    if (f3 == 5) imm = imm & 32'h41F;
    if ((l >> 31) == 0)
      r = (imm << 20) | (rs1 << 15) | (f3 << 12)
        | (rd << 7) | 32'd19;
`else
    imm = 0;
    r = r | imm;
`endif
    return r;
  endfunction

  task automatic fill_rf();
    for (int i = 0; i < 32; i++) begin
      ref_rf[i] = $urandom;
      dut_rf[i] = ref_rf[i];
    end
    dut_rf[0] = ~ref_rf[0];
  endtask

  task automatic run_check(input string tag, input bit hold);
    int          first_bad;
    logic [31:0] exp;
    logic [6:0]  opc;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic        exp_m;
    first_bad = 0;
    for (int i = 31; i >= 1; i--)
      if (dut_rf[i] !== ref_rf[i]) first_bad = i;
    run_seq.delete();
    bus.start = 1'b1;
    @(negedge clk);
    if (!hold) bus.start = 1'b0;
    for (int k = 0; k < NI; k++) begin
      exp = m_enc(model_l);
      model_l = m_next(model_l);
      run_seq.push_back(bus.instr_out);
      checks++;
      if (bus.instr_out !== exp || bus.instr_valid !== 1'b1
          || bus.busy !== 1'b1 || bus.done !== 1'b0
          || bus.mismatch !== 1'b0
          || bus.issued_cnt !== 16'(k + 1)) begin
        errors++;
        $display("FAIL %s issue%0d: instr=%h valid=%b busy=%b done=%b mism=%b cnt=%0d, want instr=%h valid=1 busy=1 done=0 mism=0 cnt=%0d",
                 tag, k, bus.instr_out, bus.instr_valid, bus.busy,
                 bus.done, bus.mismatch, bus.issued_cnt, exp, k + 1);
      end
      opc = bus.instr_out[6:0];
      f3  = bus.instr_out[14:12];
      f7  = bus.instr_out[31:25];
      checks++;
      if (opc == 7'b0010011) begin
`ifdef IMM_TYPE_EN
        if (f3 == 3'd1 && f7 != 7'd0) begin
          errors++;
          $display("FAIL %s slli_imm%0d: instr=%h, want imm[11:5]=0",
                   tag, k, bus.instr_out);
        end
`else
        errors++;
        $display("FAIL %s opcode%0d: instr=%h, want opcode 0110011",
                 tag, k, bus.instr_out);
`endif
      end else if (opc != 7'b0110011
                   || (f7 != 7'd0 && f3 != 3'd0 && f3 != 3'd5)) begin
        errors++;
        $display("FAIL %s rtype%0d: instr=%h, want opcode 0110011 and f7=0 unless funct3 0/5",
                 tag, k, bus.instr_out);
      end
      @(negedge clk);
    end
    for (int d = 0; d < DC; d++) begin
      checks++;
      if (bus.instr_out !== NOP || bus.instr_valid !== 1'b1
          || bus.busy !== 1'b1
          || bus.issued_cnt !== 16'(NI)) begin
        errors++;
        $display("FAIL %s drain%0d: instr=%h valid=%b busy=%b cnt=%0d, want instr=%h valid=1 busy=1 cnt=%0d",
                 tag, d, bus.instr_out, bus.instr_valid, bus.busy,
                 bus.issued_cnt, NOP, NI);
      end
      @(negedge clk);
    end
    for (int i = 1; i <= 31; i++) begin
      exp_m = (first_bad != 0 && first_bad < i);
      checks++;
      if (bus.rf_idx !== 5'(i) || bus.instr_valid !== 1'b0
          || bus.instr_out !== NOP || bus.busy !== 1'b1
          || bus.done !== 1'b0 || bus.mismatch !== exp_m) begin
        errors++;
        $display("FAIL %s cmp%0d: idx=%0d valid=%b instr=%h busy=%b done=%b mism=%b, want idx=%0d valid=0 instr=%h busy=1 done=0 mism=%b",
                 tag, i, bus.rf_idx, bus.instr_valid, bus.instr_out,
                 bus.busy, bus.done, bus.mismatch, i, NOP, exp_m);
      end
      @(negedge clk);
    end
    if (hold) bus.start = 1'b0;
    for (int r = 0; r < 2; r++) begin
      checks++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0
          || bus.instr_valid !== 1'b0 || bus.instr_out !== NOP
          || bus.rf_idx !== 5'd0
          || bus.mismatch !== (first_bad != 0)
          || bus.mismatch_idx !== 5'(first_bad)
          || bus.issued_cnt !== 16'(NI)) begin
        errors++;
        $display("FAIL %s done%0d: done=%b busy=%b valid=%b instr=%h idx=%0d mism=%b midx=%0d cnt=%0d, want done=1 busy=0 valid=0 instr=%h idx=0 mism=%b midx=%0d cnt=%0d",
                 tag, r, bus.done, bus.busy, bus.instr_valid,
                 bus.instr_out, bus.rf_idx, bus.mismatch,
                 bus.mismatch_idx, bus.issued_cnt, NOP,
                 first_bad != 0, first_bad, NI);
      end
      @(negedge clk);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    checks++;
    if (bus.instr_out !== NOP || bus.instr_valid !== 1'b0
        || bus.rf_idx !== 5'd0 || bus.busy !== 1'b0
        || bus.done !== 1'b0 || bus.mismatch !== 1'b0
        || bus.mismatch_idx !== 5'd0
        || bus.issued_cnt !== 16'd0) begin
      errors++;
      $display("FAIL %s: instr=%h valid=%b idx=%0d busy=%b done=%b mism=%b midx=%0d cnt=%0d, want reset values",
               tag, bus.instr_out, bus.instr_valid, bus.rf_idx,
               bus.busy, bus.done, bus.mismatch, bus.mismatch_idx,
               bus.issued_cnt);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    reset = 1'b1;
    model_l = SEED;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check_reset_vals($sformatf("reset_idle%0d", c));
    end
  endtask

  task automatic test_basic();
    fill_rf();
    run_check("basic", 1'b0);
    first_seq = run_seq;
  endtask

  task automatic test_seed_sequence();
    logic [31:0] l;
    l = SEED;
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (first_seq[k] !== m_enc(l)) begin
        errors++;
        $display("FAIL seed_seq%0d: got=%h want=%h",
                 k, first_seq[k], m_enc(l));
      end
      l = m_next(l);
    end
  endtask

  task automatic test_mismatch();
    fill_rf();
    dut_rf[7]  = ref_rf[7] ^ 32'h0000_0100;
    dut_rf[20] = ref_rf[20] ^ 32'h8000_0000;
    run_check("mismatch", 1'b0);
  endtask

  task automatic test_reset_mid_run();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.issued_cnt !== 16'd2) begin
      errors++;
      $display("FAIL midrun_cnt: cnt=%0d want=2", bus.issued_cnt);
    end
    reset = 1'b1;
    #1;
    check_reset_vals("midrun_async");
    @(negedge clk);
    check_reset_vals("midrun_next");
    reset = 1'b0;
    model_l = SEED;
    @(negedge clk);
    fill_rf();
    run_check("replay", 1'b0);
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (run_seq[k] !== first_seq[k]) begin
        errors++;
        $display("FAIL replay_seq%0d: got=%h want=%h",
                 k, run_seq[k], first_seq[k]);
      end
    end
  endtask

  task automatic test_hold_restart();
    logic [31:0] seq_a [$];
    bit          same;
    fill_rf();
    dut_rf[12] = ~ref_rf[12];
    run_check("hold", 1'b1);
    seq_a = run_seq;
    fill_rf();
    run_check("restart", 1'b0);
    same = 1'b1;
    for (int k = 0; k < NI; k++)
      if (run_seq[k] !== seq_a[k]) same = 1'b0;
    checks++;
    if (same) begin
      errors++;
      $display("FAIL restart_fresh: second run repeated first sequence %h",
               seq_a[0]);
    end
  endtask

  task automatic test_random_runs();
    int n;
    for (int r = 0; r < 4; r++) begin
      fill_rf();
      if (r == 0) dut_rf[31] = ref_rf[31] ^ 32'd1;
      if (r == 1) dut_rf[1]  = ref_rf[1] ^ 32'h10;
      n = $urandom_range(0, 2);
      for (int j = 0; j < n; j++) begin
        int idx;
        idx = $urandom_range(1, 31);
        dut_rf[idx] = ref_rf[idx] ^ (32'd1 << $urandom_range(0, 31));
      end
      run_check($sformatf("rand%0d", r), 1'b0);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      dut_rf[i] = 32'd0;
      ref_rf[i] = 32'd0;
    end
    test_reset();
    test_basic();
    test_seed_sequence();
    test_mismatch();
    test_reset_mid_run();
    test_hold_restart();
    test_random_runs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
